// File: rtl/ram_sdp_be_clr.sv
// rtl/ram_sdp_be_clr.sv - simple-dual-port sync-read RAM with byte enables and zero-fill sweep
module ram_sdp_be_clr #(
  parameter int AWIDTH         = 3,
  parameter int DWIDTH         = 32,
  parameter int BWIDTH         = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [AWIDTH-1:0]          wr_addr,
  input  logic [DWIDTH-1:0]          wr_data,
  input  logic [DWIDTH/BWIDTH-1:0]   wr_be,
  input  logic                       rd_en,
  input  logic [AWIDTH-1:0]          rd_addr,
  input  logic                       clr_req,
  output logic [DWIDTH-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       ready
);

  localparam int DEPTH  = 1 << AWIDTH;
  localparam int NBYTES = DWIDTH / BWIDTH;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t              state, state_nxt;
  logic [AWIDTH-1:0]   clr_addr, clr_addr_nxt;
  logic [DWIDTH-1:0]   mem [DEPTH];
  logic [DWIDTH-1:0]   rd_word;
  logic                wr_acc;
  logic                rd_acc;

  assign ready  = (state == S_READY);
  assign wr_acc = ready & wr_en;
  assign rd_acc = ready & rd_en;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // The edge writing the last address leaves CLEAR; clr_addr wraps to 0 by itself.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    case (state)
      S_CLEAR: begin
        clr_addr_nxt = clr_addr + 1'b1;
        if (clr_addr == {AWIDTH{1'b1}}) begin
          state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (clr_req) begin
          state_nxt    = S_CLEAR;
          clr_addr_nxt = '0;
        end
      end
      default: begin
        state_nxt    = S_CLEAR;
        clr_addr_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (state == S_CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BWIDTH +: BWIDTH] <= wr_data[i*BWIDTH +: BWIDTH];
        end
      end
    end
  end

  // New-data mode forwards the enabled write lanes over the old word.
  always_comb begin
    rd_word = mem[rd_addr];
    if ((RDW_MODE == 1) && wr_acc && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be[i]) begin
          rd_word[i*BWIDTH +: BWIDTH] = wr_data[i*BWIDTH +: BWIDTH];
        end
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DWIDTH-1:0] stage_data;
      logic              stage_valid;

      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          stage_data  <= '0;
          stage_valid <= 1'b0;
          rd_data     <= '0;
          rd_valid    <= 1'b0;
        end else begin
          stage_valid <= rd_acc;
          if (rd_acc) begin
            stage_data <= rd_word;
          end
          rd_valid <= stage_valid;
          if (stage_valid) begin
            rd_data <= stage_data;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) begin
            rd_data <= rd_word;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_sdp_be_clr.sv
// tb/tb_ram_sdp_be_clr.sv - directed bench: latency-1/old-data, latency-2/new-data and no-clear instances
module tb_ram_sdp_be_clr;

  logic        clock;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic        clr_req;

  logic [31:0] d0_data, d1_data, nc_data;
  logic        d0_valid, d1_valid, nc_valid;
  logic        d0_ready, d1_ready, nc_ready;

  int n_cmp = 0;
  int n_err = 0;

  ram_sdp_be_clr u_d0 (
    .clock(clock), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .clr_req(clr_req),
    .rd_data(d0_data), .rd_valid(d0_valid), .ready(d0_ready)
  );

  ram_sdp_be_clr #(.RD_LATENCY(2), .RDW_MODE(1)) u_d1 (
    .clock(clock), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .clr_req(clr_req),
    .rd_data(d1_data), .rd_valid(d1_valid), .ready(d1_ready)
  );

  ram_sdp_be_clr #(.CLEAR_ON_RESET(0)) u_nc (
    .clock(clock), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .clr_req(clr_req),
    .rd_data(nc_data), .rd_valid(nc_valid), .ready(nc_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
    tick;
    wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e);
    rd_en   = 1'b1;
    rd_addr = a;
    tick;
    rd_en   = 1'b0;
    check_eq("rd_l1_valid", d0_valid, 1);
    check_eq("rd_l1_data", d0_data, e);
    tick;
    check_eq("rd_l1_drop", d0_valid, 0);
    check_eq("rd_l2_valid", d1_valid, 1);
    check_eq("rd_l2_data", d1_data, e);
  endtask

  // Counts 8 edges from the current point; ready must rise on the 8th only.
  task automatic sweep_wait;
    for (int k = 1; k <= 8; k++) begin
      tick;
      check_eq("sweep_ready_l1", d0_ready, (k == 8));
      check_eq("sweep_ready_l2", d1_ready, (k == 8));
      check_eq("sweep_no_valid", d1_valid, 0);
    end
  endtask

  initial begin
    idle;
    wr_addr = '0;
    wr_data = '0;
    wr_be   = '0;
    rd_addr = '0;
    rst_n   = 1'b0;
    repeat (2) tick;
    check_eq("rst_ready", d0_ready, 0);
    check_eq("rst_valid", d0_valid, 0);
    check_eq("rst_data", d0_data, 0);
    check_eq("rst_l2_valid", d1_valid, 0);
    check_eq("rst_l2_data", d1_data, 0);
    check_eq("noclr_ready", nc_ready, 1);

    rst_n = 1'b1;
    sweep_wait;
    for (int a = 0; a < 8; a++) rd(a[2:0], 32'h0);

    wr(3'd5, 32'hDEADBEEF, 4'b1111);
    wr(3'd5, 32'h11223344, 4'b0101);
    rd(3'd5, 32'hDE22BE44);

    wr(3'd2, 32'hAAAAAAAA, 4'b1111);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h55555555; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 3'd2;
    tick;
    idle;
    check_eq("rdw_old_full", d0_data, 32'hAAAAAAAA);
    tick;
    check_eq("rdw_new_full_v", d1_valid, 1);
    check_eq("rdw_new_full", d1_data, 32'h55555555);

    wr(3'd2, 32'hAAAAAAAA, 4'b1111);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h55555555; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 3'd2;
    tick;
    idle;
    check_eq("rdw_old_part", d0_data, 32'hAAAAAAAA);
    tick;
    check_eq("rdw_new_part", d1_data, 32'hAAAA5555);
    rd(3'd2, 32'hAAAA5555);

    for (int k = 0; k < 8; k++) wr(k[2:0], k, 4'b1111);
    rd_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      rd_addr = i[2:0];
      tick;
      check_eq("b2b_l1_data", d0_data, i);
      check_eq("b2b_l1_valid", d0_valid, 1);
      check_eq("b2b_l2_valid", d1_valid, (i > 1));
      if (i > 1) check_eq("b2b_l2_data", d1_data, i - 1);
    end
    rd_en = 1'b0;
    tick;
    check_eq("b2b_l2_last_v", d1_valid, 1);
    check_eq("b2b_l2_last", d1_data, 3);
    check_eq("b2b_l1_idle", d0_valid, 0);
    tick;
    check_eq("b2b_l2_idle", d1_valid, 0);
    check_eq("b2b_l2_hold", d1_data, 3);

    for (int k = 0; k < 8; k++) wr(k[2:0], 32'hFFFFFFFF, 4'b1111);
    clr_req = 1'b1; rd_en = 1'b1; rd_addr = 3'd3;
    tick;
    idle;
    check_eq("clr_rd_valid", d0_valid, 1);
    check_eq("clr_rd_data", d0_data, 32'hFFFFFFFF);
    check_eq("clr_ready", d0_ready, 0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h12345678; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 3'd3;
    for (int k = 1; k <= 8; k++) begin
      clr_req = (k == 4);
      tick;
      check_eq("clr_sweep_ready", d0_ready, (k == 8));
      check_eq("clr_no_l1_valid", d0_valid, 0);
      check_eq("clr_l2_drain_v", d1_valid, (k == 1));
      if (k == 1) check_eq("clr_l2_drain", d1_data, 32'hFFFFFFFF);
    end
    idle;
    for (int a = 0; a < 8; a++) rd(a[2:0], 32'h0);

    for (int k = 0; k < 8; k++) wr(k[2:0], 32'hFFFFFFFF, 4'b1111);
    clr_req = 1'b1;
    tick;
    idle;
    repeat (4) tick;
    rst_n = 1'b0;
    #1;
    check_eq("midclr_rst_ready", d0_ready, 0);
    check_eq("midclr_rst_valid", d0_valid, 0);
    check_eq("midclr_rst_l2_v", d1_valid, 0);
    tick;
    rst_n = 1'b1;
    sweep_wait;
    for (int a = 0; a < 8; a++) rd(a[2:0], 32'h0);

    wr(3'd1, 32'hCAFEF00D, 4'b1111);
    rd_en = 1'b1; rd_addr = 3'd1;
    tick;
    rd_en = 1'b0;
    check_eq("midrd_valid", d0_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrd_rst_valid", d0_valid, 0);
    check_eq("midrd_rst_data", d0_data, 0);
    tick;
    rst_n = 1'b1;
    sweep_wait;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
